dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the data bus.
REQ-002 Parameter ADDR_WIDTH, default 16: byte-address bits decoded; the array holds 2^ADDR_WIDTH bytes.
REQ-003 Parameter LATENCY, default 2, legal range 1..15: cycles from request accept to response valid.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-low reset.
REQ-006 Port req_valid_i  input  1  the core presents a request.
REQ-007 Port req_ready_o  output  1  the responder can accept a request this cycle.
REQ-008 Port req_addr_i  input  32  byte address of the request.
REQ-009 Port req_we_i  input  1  1 selects a store, 0 selects a load.
REQ-010 Port req_type_i  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-011 Port req_sign_i  input  1  1 selects a sign-extended load, 0 selects a zero-extended load.
REQ-012 Port req_wdata_i  input  DATA_WIDTH  store data, taken from the low-order bytes.
REQ-013 Port rsp_valid_o  output  1  a response is pending.
REQ-014 Port rsp_ready_i  input  1  the core consumes the response.
REQ-015 Port rsp_rdata_o  output  DATA_WIDTH  load data; 0 for stores and for errors.
REQ-016 Port rsp_err_o  output  1  the request was misaligned or illegal.
REQ-017 Port busy_o  output  1  a request is in flight; the core uses this as its memory-stage stall.

Function
REQ-018 The FSM SHALL have three states, IDLE, WAIT and RESP, and SHALL assert req_ready_o only in IDLE, so that at most one request is outstanding.
REQ-019 A request is accepted on a rising edge where req_valid_i=1 and req_ready_o=1; on that edge the responder SHALL latch the address, type, sign and we fields.
REQ-020 On the accepting edge the FSM SHALL go to RESP if LATENCY=1, otherwise to WAIT with the down-counter loaded with LATENCY-1.
REQ-021 In WAIT the counter SHALL decrement once per cycle, and the FSM SHALL go to RESP on the edge where the counter reaches 1.
REQ-022 rsp_valid_o SHALL be 1 exactly in RESP, so it rises LATENCY cycles after the accepting edge.
REQ-023 In RESP, rsp_rdata_o and rsp_err_o SHALL hold stable until an edge with rsp_ready_i=1, which returns the FSM to IDLE.
REQ-024 busy_o SHALL equal (state != IDLE).
REQ-025 A new request SHALL NOT be accepted on the same edge that retires a response; req_ready_o rises the cycle after retirement.
REQ-026 Alignment: a half access with addr[0]=1, a word access with addr[1:0]!=00, or req_type_i=11 SHALL produce rsp_err_o=1 and rsp_rdata_o=0, with no memory write.
REQ-027 Storage SHALL be little-endian, and addresses SHALL be taken modulo 2^ADDR_WIDTH; upper address bits are ignored, so accesses wrap.
REQ-028 A legal store SHALL write its 1, 2 or 4 bytes on the accepting edge; all other bytes SHALL be unchanged.
REQ-029 Load data SHALL be read from the array in the last WAIT cycle, or on the accepting edge when LATENCY=1, and registered into rsp_rdata_o.
REQ-030 A load accepted after a store SHALL observe the stored data.
REQ-031 Load extension: byte and half loads SHALL be sign-extended when req_sign_i=1 and zero-extended when req_sign_i=0; for word loads req_sign_i SHALL be ignored.
REQ-032 A store response SHALL return rsp_rdata_o=0 and rsp_err_o=0.

Reset
REQ-033 On rst=0, asynchronously: state goes to IDLE, the counter goes to 0, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0 and busy_o=0.
REQ-034 While rst=0, req_ready_o SHALL be 0; it SHALL be 1 in the first cycle after rst is released.
REQ-035 Reset SHALL NOT clear the memory array.
REQ-036 A reset asserted mid-transaction SHALL abort it with no response; a store already committed on its accepting edge SHALL remain written.

Verification
REQ-037 LATENCY=2: store word 0xDEADBEEF to 0x100, then load word from 0x100 -> rsp_valid_o rises 2 cycles after each accept; load returns 0xDEADBEEF with rsp_err_o=0.
REQ-038 After REQ-037: load byte at 0x103 with sign=1 -> 0xFFFFFFDE; with sign=0 -> 0x000000DE; load half at 0x100 with sign=1 -> 0xFFFFBEEF.
REQ-039 Store half 0x1234 to 0x102 over 0xDEADBEEF at 0x100 -> a subsequent word load from 0x100 returns 0x1234BEEF.
REQ-040 Load word from 0x101, and issue a request with req_type_i=11 -> rsp_err_o=1 and rsp_rdata_o=0; a store word to 0x102 -> rsp_err_o=1 and memory unchanged.
REQ-041 Hold rsp_ready_i=0 for 5 cycles in RESP -> rdata stable, req_ready_o=0, busy_o=1; raising rsp_ready_i -> IDLE on the next edge.
REQ-042 Assert rst=0 in WAIT after a store of 0x55 to 0x10 -> no response, outputs zero immediately; after release, a byte load from 0x10 returns 0x00000055.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: byte-addressed little-endian array
// with fixed-latency, backpressured responses and alignment checking.
module dmem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [31:0]           req_addr_i,
    input  logic                  req_we_i,
    input  logic [1:0]            req_type_i,
    input  logic                  req_sign_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateE;

    localparam logic [1:0] TYPE_BYTE = 2'b00;
    localparam logic [1:0] TYPE_HALF = 2'b01;
    localparam logic [1:0] TYPE_WORD = 2'b10;

    stateE                  state, nextState;
    logic [3:0]             count;
    logic [ADDR_WIDTH-1:0]  addrQ;
    logic [1:0]             typeQ;
    logic                   signQ, weQ;
    logic [DATA_WIDTH-1:0]  rdataQ;
    logic                   errQ;

    // NOTE: the array is deliberately left out of reset; contents must survive rst.
    logic [7:0]             mem [2**ADDR_WIDTH];

    logic                   accept, inIdle, loadRsp;
    logic [ADDR_WIDTH-1:0]  selAddr;
    logic [1:0]             selType;
    logic                   selSign, selWe, selErr;
    logic [3:0][7:0]        rdBytes;
    logic [3:0]             byteEn;
    logic [DATA_WIDTH-1:0]  loadData, respData;
    logic                   unusedAddrBits;

    assign unusedAddrBits = ^req_addr_i[31:ADDR_WIDTH];

    assign accept  = req_valid_i & req_ready_o;
    assign inIdle  = (state == IDLE);
    // With LATENCY=1 the read happens on the accepting edge, so use the live request fields.
    assign selAddr = inIdle ? req_addr_i[ADDR_WIDTH-1:0] : addrQ;
    assign selType = inIdle ? req_type_i : typeQ;
    assign selSign = inIdle ? req_sign_i : signQ;
    assign selWe   = inIdle ? req_we_i   : weQ;
    assign loadRsp = (accept && LATENCY == 1) || (state == WAIT && count == 4'd1);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        selErr = 1'b0;
        byteEn = 4'b0001;
        case (selType)
            TYPE_BYTE: byteEn = 4'b0001;
            TYPE_HALF: begin
                selErr = selAddr[0];
                byteEn = 4'b0011;
            end
            TYPE_WORD: begin
                selErr = (selAddr[1:0] != 2'b00);
                byteEn = 4'b1111;
            end
            default:   selErr = 1'b1;
        endcase
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rdBytes[k] = mem[selAddr + ADDR_WIDTH'(k)];
        end
        loadData = DATA_WIDTH'(rdBytes);
        case (selType)
            TYPE_BYTE: loadData = {{(DATA_WIDTH-8){selSign & rdBytes[0][7]}}, rdBytes[0]};
            TYPE_HALF: loadData = {{(DATA_WIDTH-16){selSign & rdBytes[1][7]}}, rdBytes[1], rdBytes[0]};
            default:   loadData = DATA_WIDTH'(rdBytes);
        endcase
        respData = (selWe || selErr) ? '0 : loadData;
    end

    // Stores commit on the accepting edge; misaligned or illegal stores never write.
    always_ff @(posedge clk) begin
        if (accept && req_we_i && !selErr) begin
            for (int k = 0; k < 4; k++) begin
                if (byteEn[k]) begin
                    mem[req_addr_i[ADDR_WIDTH-1:0] + ADDR_WIDTH'(k)] <= req_wdata_i[8*k +: 8];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (accept) nextState = (LATENCY == 1) ? RESP : WAIT;
            WAIT: if (count == 4'd1) nextState = RESP;
            RESP: if (rsp_ready_i) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = rst && (state == IDLE);
        rsp_valid_o = (state == RESP);
        busy_o      = (state != IDLE);
        rsp_rdata_o = rdataQ;
        rsp_err_o   = errQ;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            addrQ  <= '0;
            typeQ  <= '0;
            signQ  <= 1'b0;
            weQ    <= 1'b0;
            rdataQ <= '0;
            errQ   <= 1'b0;
        end else begin
            if (accept) begin
                count <= 4'(LATENCY - 1);
                addrQ <= req_addr_i[ADDR_WIDTH-1:0];
                typeQ <= req_type_i;
                signQ <= req_sign_i;
                weQ   <= req_we_i;
            end else if (state == WAIT) begin
                count <= count - 4'd1;
            end
            // Response registers are only meaningful in RESP and read zero otherwise.
            if (loadRsp) begin
                rdataQ <= respData;
                errQ   <= selErr;
            end else if (state == RESP && rsp_ready_i) begin
                rdataQ <= '0;
                errQ   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// traffic compared against a byte-array reference model.
module tb_dmem_responder;

    localparam int DW  = 32;
    localparam int AW  = 16;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [31:0]   req_addr = '0;
    logic          req_we = 1'b0;
    logic [1:0]    req_type = 2'b00;
    logic          req_sign = 1'b0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mdl [0:65535];

    always #5 clk = ~clk;

    dmem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_we_i(req_we), .req_type_i(req_type), .req_sign_i(req_sign),
        .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .busy_o(busy)
    );

    // Reference behaviour: little-endian byte array, 64 KiB wrap, alignment rules.
    function automatic void model_op(input logic [31:0] a, input logic we, input logic [1:0] t,
                                     input logic s, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic er);
        int n;
        logic [31:0] v;
        logic [15:0] idx;
        n  = (t == 2'b00) ? 1 : (t == 2'b01) ? 2 : 4;
        er = (t == 2'b11) || (t == 2'b01 && a[0]) || (t == 2'b10 && a[1:0] != 2'b00);
        rd = 32'h0;
        v  = 32'h0;
        if (er) return;
        for (int i = 0; i < n; i++) begin
            idx = a[15:0] + 16'(i);
            if (we) mdl[idx] = wd[8*i +: 8];
            else    v = v | (32'(mdl[idx]) << (8*i));
        end
        if (!we) begin
            rd = v;
            if (s && n < 4 && v[8*n-1]) rd = v | (32'hFFFF_FFFF << (8*n));
        end
    endfunction

    task automatic send_req(input logic [31:0] a, input logic we, input logic [1:0] t,
                            input logic s, input logic [31:0] wd);
        int guard = 0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_we = we; req_type = t; req_sign = s; req_wdata = wd;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout: req_ready stayed %b, required 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // lat counts rising edges from the accepting edge (1) to the one that raises rsp_valid.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic retire();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic transact(input logic [31:0] a, input logic we, input logic [1:0] t,
                            input logic s, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er, output int lat,
                            output logic [31:0] exp_rd, output logic exp_er);
        model_op(a, we, t, s, wd, exp_rd, exp_er);
        send_req(a, we, t, s, wd);
        wait_rsp(lat);
        rd = rsp_rdata;
        er = rsp_err;
        retire();
    endtask

    task automatic expect_rsp(input string name, input logic [31:0] rd, input logic er,
                              input int lat, input logic [31:0] want_rd, input logic want_er);
        vectors++;
        if ({lat[7:0], er, rd} !== {8'(LAT), want_er, want_rd}) begin
            miscompares++;
            $display("FAIL %s: got lat=%0d err=%b rdata=%h, required lat=%0d err=%b rdata=%h",
                     name, lat, er, rd, LAT, want_er, want_rd);
        end
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({req_ready, rsp_valid, busy, rsp_err, rsp_rdata} !== 36'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got ready=%b valid=%b busy=%b err=%b rdata=%h, required all 0",
                     req_ready, rsp_valid, busy, rsp_err, rsp_rdata);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({req_ready, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_release: got ready=%b busy=%b, required ready=1 busy=0", req_ready, busy);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd, erd; logic er, eer; int lat;
        transact(32'h100, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, rd, er, lat, erd, eer);
        expect_rsp("store_word_0x100", rd, er, lat, 32'h0, 1'b0);
        transact(32'h100, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat, erd, eer);
        expect_rsp("load_word_0x100", rd, er, lat, 32'hDEADBEEF, 1'b0);
    endtask

    task automatic test_extension();
        logic [31:0] rd, erd; logic er, eer; int lat;
        transact(32'h103, 1'b0, 2'b00, 1'b1, 32'h0, rd, er, lat, erd, eer);
        expect_rsp("load_byte_signed", rd, er, lat, 32'hFFFFFFDE, 1'b0);
        transact(32'h103, 1'b0, 2'b00, 1'b0, 32'h0, rd, er, lat, erd, eer);
        expect_rsp("load_byte_unsigned", rd, er, lat, 32'h000000DE, 1'b0);
        transact(32'h100, 1'b0, 2'b01, 1'b1, 32'h0, rd, er, lat, erd, eer);
        expect_rsp("load_half_signed", rd, er, lat, 32'hFFFFBEEF, 1'b0);
        transact(32'h102, 1'b0, 2'b01, 1'b0, 32'h0, rd, er, lat, erd, eer);
        expect_rsp("load_half_unsigned", rd, er, lat, 32'h0000DEAD, 1'b0);
        transact(32'h100, 1'b0, 2'b10, 1'b1, 32'h0, rd, er, lat, erd, eer);
        expect_rsp("load_word_sign_ignored", rd, er, lat, 32'hDEADBEEF, 1'b0);
    endtask

    task automatic test_half_store();
        logic [31:0] rd, erd; logic er, eer; int lat;
        transact(32'h102, 1'b1, 2'b01, 1'b0, 32'hCAFE1234, rd, er, lat, erd, eer);
        expect_rsp("store_half_0x102", rd, er, lat, 32'h0, 1'b0);
        transact(32'h100, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat, erd, eer);
        expect_rsp("load_after_half_store", rd, er, lat, 32'h1234BEEF, 1'b0);
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd; logic er, eer; int lat;
        transact(32'h101, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat, erd, eer);
        expect_rsp("misaligned_word_load", rd, er, lat, 32'h0, 1'b1);
        transact(32'h101, 1'b0, 2'b01, 1'b1, 32'h0, rd, er, lat, erd, eer);
        expect_rsp("misaligned_half_load", rd, er, lat, 32'h0, 1'b1);
        transact(32'h100, 1'b0, 2'b11, 1'b0, 32'h0, rd, er, lat, erd, eer);
        expect_rsp("illegal_type", rd, er, lat, 32'h0, 1'b1);
        transact(32'h102, 1'b1, 2'b10, 1'b0, 32'h11223344, rd, er, lat, erd, eer);
        expect_rsp("misaligned_word_store", rd, er, lat, 32'h0, 1'b1);
        transact(32'h100, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat, erd, eer);
        expect_rsp("memory_unchanged_after_err", rd, er, lat, 32'h1234BEEF, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [31:0] erd; logic eer; int lat;
        model_op(32'h100, 1'b0, 2'b10, 1'b0, 32'h0, erd, eer);
        send_req(32'h100, 1'b0, 2'b10, 1'b0, 32'h0);
        wait_rsp(lat);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            vectors++;
            if ({rsp_valid, req_ready, busy, rsp_err, rsp_rdata} !== {4'b1010, 32'h1234BEEF}) begin
                miscompares++;
                $display("FAIL hold_cycle_%0d: got valid=%b ready=%b busy=%b err=%b rdata=%h, required 1/0/1/0/1234beef",
                         c, rsp_valid, req_ready, busy, rsp_err, rsp_rdata);
            end
        end
        // A request waiting during the retiring edge must not be taken on that edge.
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h100; req_we = 1'b0; req_type = 2'b00; req_sign = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        vectors++;
        if ({rsp_valid, busy, req_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL retire_edge: got valid=%b busy=%b ready=%b, required 0/0/1", rsp_valid, busy, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        vectors++;
        if ({busy, req_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL accept_after_retire: got busy=%b ready=%b, required 1/0", busy, req_ready);
        end
        model_op(32'h100, 1'b0, 2'b00, 1'b0, 32'h0, erd, eer);
        wait_rsp(lat);
        expect_rsp("load_after_retire", rsp_rdata, rsp_err, lat, erd, eer);
        retire();
    endtask

    task automatic test_wrap();
        logic [31:0] rd, erd; logic er, eer; int lat;
        transact(32'hFFFF0300, 1'b1, 2'b10, 1'b0, 32'h12345678, rd, er, lat, erd, eer);
        expect_rsp("store_high_alias", rd, er, lat, 32'h0, 1'b0);
        transact(32'h00000300, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat, erd, eer);
        expect_rsp("load_low_alias", rd, er, lat, 32'h12345678, 1'b0);
        transact(32'h8001FFFF, 1'b1, 2'b00, 1'b0, 32'h000000A5, rd, er, lat, erd, eer);
        transact(32'h0000FFFF, 1'b0, 2'b00, 1'b1, 32'h0, rd, er, lat, erd, eer);
        expect_rsp("top_byte_alias", rd, er, lat, 32'hFFFFFFA5, 1'b0);
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd, erd; logic er, eer; int lat, seen;
        model_op(32'h10, 1'b1, 2'b00, 1'b0, 32'h55, erd, eer);
        send_req(32'h10, 1'b1, 2'b00, 1'b0, 32'h00000055);
        #1 rst = 1'b0;
        #1;
        vectors++;
        if ({rsp_valid, busy, req_ready, rsp_err, rsp_rdata} !== 36'h0) begin
            miscompares++;
            $display("FAIL abort_outputs: got valid=%b busy=%b ready=%b err=%b rdata=%h, required all 0",
                     rsp_valid, busy, req_ready, rsp_err, rsp_rdata);
        end
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rsp_valid || busy) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL abort_no_response: got %0d active cycles, required 0", seen);
        end
        transact(32'h10, 1'b0, 2'b00, 1'b0, 32'h0, rd, er, lat, erd, eer);
        expect_rsp("committed_store_survives", rd, er, lat, 32'h00000055, 1'b0);
        transact(32'h100, 1'b0, 2'b10, 1'b0, 32'h0, rd, er, lat, erd, eer);
        expect_rsp("array_not_cleared", rd, er, lat, 32'h1234BEEF, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a, wd; logic er, eer, we, s; logic [1:0] t; int lat;
        for (int i = 0; i < 16; i++) begin
            a = 32'h200 + 32'(4*i);
            transact(a, 1'b1, 2'b10, 1'b0, $urandom, rd, er, lat, erd, eer);
            expect_rsp("prefill", rd, er, lat, erd, eer);
        end
        for (int i = 0; i < 80; i++) begin
            a  = {16'($urandom), 16'h0200 + 16'($urandom_range(0, 63))};
            we = 1'($urandom);
            t  = 2'($urandom_range(0, 3));
            s  = 1'($urandom);
            wd = $urandom;
            transact(a, we, t, s, wd, rd, er, lat, erd, eer);
            expect_rsp($sformatf("random_%0d", i), rd, er, lat, erd, eer);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store_load();
        test_extension();
        test_half_store();
        test_errors();
        test_backpressure();
        test_wrap();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
